cuatro_b: RTL and testbench

CUATRO_B -- requirements
Module: cuatro_b

---
 rtl/cuatro_b.sv | 58 +++++
 tb/tb_cuatro_b.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/cuatro_b.sv
// cuatro_b: registered threshold (majority) and odd-parity flags over a 6-bit word.
// W = {a,b,c,d,e,f}. x is set when popcount(W) >= MAJ_THRESHOLD, y is set when
// popcount(W) is odd. Both flags are flops, so results appear one clock after
// the word is sampled.
module cuatro_b #(
   parameter int unsigned MAJ_THRESHOLD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   input  logic e,
   input  logic f,
   output logic x,
   output logic y
);

   localparam int unsigned WORD_W = 6;
   localparam int unsigned CNT_W  = 3;
   localparam logic [CNT_W-1:0] THRESH = CNT_W'(MAJ_THRESHOLD);

   logic [WORD_W-1:0] w_word;
   logic [CNT_W-1:0]  w_cnt;
   logic              w_x_nxt;
   logic              w_y_nxt;
   logic              r_x;
   logic              r_y;

   assign w_word = {a, b, c, d, e, f};

   // Count the ones in the input word.
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < int'(WORD_W); i++) begin
         w_cnt = w_cnt + CNT_W'(w_word[i]);
      end
   end

   assign w_x_nxt = (w_cnt >= THRESH);
   assign w_y_nxt = ^w_word;

   // Result flops; reset clears both flags without waiting for a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x <= 1'b0;
         r_y <= 1'b0;
      end else begin
         r_x <= w_x_nxt;
         r_y <= w_y_nxt;
      end
   end

   assign x = r_x;
   assign y = r_y;

endmodule

// File: tb/tb_cuatro_b.sv
// Self-checking bench for cuatro_b: directed reset/boundary steps, an ascending
// sweep with a mid-run reset, and randomized words with extra changes between edges.
module tb_cuatro_b;

   localparam int unsigned THR = 4;

   logic clk;
   logic rst;
   logic a, b, c, d, e, f;
   logic x, y;

   int n_checks;
   int n_pass;
   logic prev_x;
   logic prev_y;

   cuatro_b #(.MAJ_THRESHOLD(THR)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .e   (e),
      .f   (f),
      .x   (x),
      .y   (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: count ones arithmetically, compare to threshold, parity from count.
   function automatic logic ref_x(input logic [5:0] w);
      int n;
      n = 0;
      for (int i = 0; i < 6; i++) n += (w >> i) & 1;
      return (n >= int'(THR));
   endfunction

   function automatic logic ref_y(input logic [5:0] w);
      int n;
      n = 0;
      for (int i = 0; i < 6; i++) n += (w >> i) & 1;
      return (n % 2) == 1;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic drive(input logic [5:0] w);
      {a, b, c, d, e, f} = w;
   endtask

   // Apply a word just after an edge, confirm outputs hold until the next edge,
   // then confirm the registered result. Optional glitch: a random word first.
   task automatic step(input string tag, input logic [5:0] w, input bit glitch);
      logic [5:0] junk;
      if (glitch) begin
         junk = 6'($urandom_range(0, 63));
         drive(junk);
         #1;
         drive(~junk);
         #1;
      end
      drive(w);
      #1;
      check({tag, "_hold_x"}, x, prev_x);
      check({tag, "_hold_y"}, y, prev_y);
      @(posedge clk);
      #1;
      check({tag, "_x"}, x, ref_x(w));
      check({tag, "_y"}, y, ref_y(w));
      prev_x = ref_x(w);
      prev_y = ref_y(w);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;

      // Reset asserted with all ones, before any clock edge.
      rst = 1'b1;
      drive(6'b111111);
      #2;
      check("rst_noedge_x", x, 1'b0);
      check("rst_noedge_y", y, 1'b0);
      @(posedge clk);
      #1;
      check("rst_edge_x", x, 1'b0);
      check("rst_edge_y", y, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_release_x", x, 1'b1);
      check("rst_release_y", y, 1'b0);
      prev_x = 1'b1;
      prev_y = 1'b0;

      // Basic values.
      step("w00", 6'b000000, 1'b0);
      step("w01", 6'b000001, 1'b0);
      step("w3f", 6'b111111, 1'b0);

      // Threshold boundary.
      step("n3", 6'b000111, 1'b0);
      step("n4", 6'b001111, 1'b0);
      step("n5", 6'b011111, 1'b0);

      // Ascending sweep with a half-cycle reset in the middle.
      for (int i = 0; i < 64; i++) begin
         if (i == 32) begin
            drive(6'(i));
            #1;
            rst = 1'b1;
            #1;
            check("midrst_x", x, 1'b0);
            check("midrst_y", y, 1'b0);
            #5;
            rst = 1'b0;
            @(posedge clk);
            #1;
            check("midrst_resume_x", x, ref_x(6'(i)));
            check("midrst_resume_y", y, ref_y(6'(i)));
            prev_x = ref_x(6'(i));
            prev_y = ref_y(6'(i));
         end else begin
            step("sweep", 6'(i), 1'b0);
         end
      end

      // Random words with intermediate changes between edges.
      for (int i = 0; i < 40; i++) begin
         step("rand", 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
